wb_hub: RTL and testbench

WB_HUB -- requirements
Module: wb_hub

---
 rtl/wb_hub_pkg.sv | 18 +
 rtl/wb_hub_decode.sv | 27 ++
 rtl/wb_hub.sv | 118 +++++++++++
 tb/tb_wb_hub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_hub_pkg.sv
// Shared constants for the wb_hub CPU-to-Wishbone bridge: FSM encoding,
// default decode table, default timeout and counter/select widths.
package wb_hub_pkg;

    localparam int CNT_W           = 8;
    localparam int SEL_W           = 3;
    localparam int DEFAULT_TIMEOUT = 15;

    localparam logic [11:0] DEFAULT_CH_BASE = {4'h2, 4'h1, 4'h0};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/wb_hub_decode.sv
// Combinational address decode: matches addr[7:4] against the channel base
// table and returns the lowest matching channel index.
module wb_hub_decode
    import wb_hub_pkg::*;
#(
    parameter int                  NUM_CH  = 3,
    parameter logic [NUM_CH*4-1:0] CH_BASE = DEFAULT_CH_BASE
) (
    input  logic [3:0] nib,
    output sel_t       sel,
    output logic       hit
);

    // Scanning downwards lets the lowest matching index overwrite the others.
    // NOTE: both outputs get a default first so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_BASE[i*4 +: 4] == nib) begin
                hit = 1'b1;
                sel = sel_t'(i);
            end
        end
    end

endmodule

// File: rtl/wb_hub.sv
// Single-request bridge from a cs/we/addr CPU port to NUM_CH Wishbone-style
// slave channels, with decode errors, ack timeout and a registered irq OR.
module wb_hub
    import wb_hub_pkg::*;
#(
    parameter int                  NUM_CH  = 3,
    parameter int                  DW      = 8,
    parameter logic [NUM_CH*4-1:0] CH_BASE = DEFAULT_CH_BASE,
    parameter int                  TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 we,
    input  logic [7:0]           addr,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dout,
    output logic                 rdy,
    output logic                 err,
    output logic [NUM_CH-1:0]    wb_stb_o,
    output logic                 wb_rw_o,
    output logic [7:0]           wb_adr_o,
    output logic [DW-1:0]        wb_dat_o,
    input  logic [NUM_CH*DW-1:0] wb_dat_i,
    input  logic [NUM_CH-1:0]    wb_ack_i,
    input  logic [NUM_CH-1:0]    irq_i,
    output logic                 irq_o
);

    localparam cnt_t TO_LAST = cnt_t'(TIMEOUT - 1);

    logic [1:0]        state;
    cnt_t              cnt;
    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] dec_oh;
    sel_t              dec_sel;
    logic              dec_hit;
    logic              ack_sel;
    logic [DW-1:0]     rd_sel;

    wb_hub_decode #(
        .NUM_CH (NUM_CH),
        .CH_BASE(CH_BASE)
    ) u_decode (
        .nib(addr[7:4]),
        .sel(dec_sel),
        .hit(dec_hit)
    );

    // Only the latched channel's ack and data are ever looked at.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        dec_oh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dec_oh[i] = (dec_sel == sel_t'(i));
            if (sel_oh[i]) begin
                ack_sel = ack_sel | wb_ack_i[i];
                rd_sel  = rd_sel | wb_dat_i[i*DW +: DW];
            end
        end
    end

    assign wb_stb_o = (state == ST_STB) ? sel_oh : '0;
    assign rdy      = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sel_oh   <= '0;
            dout     <= '0;
            err      <= 1'b0;
            wb_rw_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            irq_o <= |irq_i;
            case (state)
                ST_IDLE: begin
                    if (cs) begin
                        wb_rw_o  <= we;
                        wb_adr_o <= addr;
                        wb_dat_o <= din;
                        cnt      <= '0;
                        if (dec_hit) begin
                            sel_oh <= dec_oh;
                            state  <= ST_STB;
                        end else begin
                            dout  <= '0;
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                // Ack is tested before the timeout so it wins a tie.
                ST_STB: begin
                    if (ack_sel) begin
                        dout  <= wb_rw_o ? '0 : rd_sel;
                        err   <= 1'b0;
                        state <= ST_DONE;
                    end else if (cnt == TO_LAST) begin
                        dout  <= '1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_hub.sv
// Randomised scoreboard bench for wb_hub: the stimulus pushes the expected
// completion, a negedge monitor pops and compares whenever rdy is seen.
module tb_wb_hub;

    localparam int          NUM_CH  = 3;
    localparam int          DW      = 8;
    localparam int          TIMEOUT = 15;
    localparam logic [11:0] CH_BASE = {4'h2, 4'h1, 4'h0};

    typedef struct {
        logic [7:0] dout;
        logic       err;
        int         cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cs = 1'b0;
    logic                 we = 1'b0;
    logic [7:0]           addr = '0;
    logic [DW-1:0]        din = '0;
    logic [DW-1:0]        dout;
    logic                 rdy;
    logic                 err;
    logic [NUM_CH-1:0]    wb_stb_o;
    logic                 wb_rw_o;
    logic [7:0]           wb_adr_o;
    logic [DW-1:0]        wb_dat_o;
    logic [NUM_CH*DW-1:0] wb_dat_i = '0;
    logic [NUM_CH-1:0]    wb_ack_i = '0;
    logic [NUM_CH-1:0]    irq_i = '0;
    logic                 irq_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    logic irq_exp = 1'b0;
    exp_t sb[$];
    logic [3:0] base_nib[NUM_CH] = '{4'h0, 4'h1, 4'h2};

    wb_hub #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .CH_BASE(CH_BASE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .rdy     (rdy),
        .err     (err),
        .wb_stb_o(wb_stb_o),
        .wb_rw_o (wb_rw_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .irq_i   (irq_i),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lowest channel whose base nibble matches the upper address nibble.
    function automatic int model_ch(input logic [7:0] a);
        for (int i = 0; i < NUM_CH; i++)
            if (base_nib[i] == a[7:4]) return i;
        return -1;
    endfunction

    // Random traffic on every channel; the addressed one gets the planned ack.
    task automatic drive_bus(input int ch, input bit ack_me, input logic [7:0] rdata);
        wb_ack_i = 3'($urandom);
        wb_dat_i = 24'($urandom);
        irq_i    = 3'($urandom);
        if (ch >= 0) begin
            wb_ack_i[ch]        = ack_me;
            wb_dat_i[ch*8 +: 8] = rdata;
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        irq_exp <= rst ? |irq_i : 1'b0;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("irq_o", 32'(irq_o), 32'(irq_exp));
            if (rdy) begin
                if (sb.size() == 0) begin
                    check("spurious_rdy", 32'(rdy), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdy_cycle", cyc, e.cyc);
                    check("dout", 32'(dout), 32'(e.dout));
                    check("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    // One CPU request; wait_n = stb cycles before the ack (>= TIMEOUT means none in time).
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int wait_n, input logic [7:0] rdata, input bit busy);
        int         ch;
        int         stb_n;
        exp_t       e;
        logic [2:0] oh;
        ch = model_ch(a);
        if (ch < 0) begin
            e.dout = 8'h00; e.err = 1'b1; stb_n = 0;
        end else if (wait_n < TIMEOUT) begin
            e.dout = w ? 8'h00 : rdata; e.err = 1'b0; stb_n = wait_n + 1;
        end else begin
            e.dout = 8'hFF; e.err = 1'b1; stb_n = TIMEOUT;
        end
        oh = (ch < 0) ? 3'b000 : 3'(1 << ch);
        @(negedge clk);
        e.cyc = cyc + stb_n + 1;
        sb.push_back(e);
        cs = 1'b1; we = w; addr = a; din = d;
        drive_bus(ch, 1'b0, rdata);
        for (int n = 0; n <= stb_n; n++) begin
            @(negedge clk);
            cs   = busy && (n == 0);
            addr = 8'h1F;
            we   = ~w;
            check("stb", 32'(wb_stb_o), (n < stb_n) ? 32'(oh) : 32'd0);
            if (n < stb_n) begin
                check("rw", 32'(wb_rw_o), 32'(w));
                check("adr", 32'(wb_adr_o), 32'(a));
                check("dat_o", 32'(wb_dat_o), 32'(d));
            end
            drive_bus(ch, n == wait_n, rdata);
        end
        @(negedge clk);
        cs = 1'b0;
        check("rdy_pulse", 32'(rdy), 32'd0);
        check("dout_hold", 32'(dout), 32'(e.dout));
        check("err_hold", 32'(err), 32'(e.err));
        check("sb_drained", sb.size(), 32'd0);
        wb_ack_i = '0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nib;
        int r;
        int wn;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_adr", 32'({wb_rw_o, wb_adr_o, wb_dat_o}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;

        txn(1'b0, 8'h14, 8'h00, 0, 8'hA5, 1'b0);            // read ch1, immediate ack
        txn(1'b1, 8'h03, 8'h5C, 3, 8'h77, 1'b0);            // write ch0, 3 waits
        txn(1'b0, 8'h70, 8'h11, 0, 8'h22, 1'b0);            // undecoded
        txn(1'b0, 8'h25, 8'h00, 99, 8'h33, 1'b0);           // timeout
        txn(1'b0, 8'h25, 8'h00, TIMEOUT - 1, 8'h3C, 1'b0);  // ack on final stb cycle
        txn(1'b0, 8'h0A, 8'h00, 2, 8'h96, 1'b1);            // busy cs + stray acks

        for (int k = 0; k < 40; k++) begin
            nib = $urandom_range(0, 4);
            if (nib == 4) nib = $urandom_range(3, 15);
            r  = $urandom_range(0, 9);
            wn = (r < 7) ? $urandom_range(0, 4) : ((r < 9) ? $urandom_range(10, 16) : 99);
            txn(1'($urandom), {4'(nib), 4'($urandom)}, 8'($urandom), wn, 8'($urandom),
                1'($urandom));
        end

        // Reset asserted during the second strobe cycle of a ch0 read.
        @(negedge clk);
        wb_ack_i = '0;
        cs = 1'b1; we = 1'b0; addr = 8'h05;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rrst_stb", 32'(wb_stb_o), 32'd0);
        check("rrst_rdy", 32'(rdy), 32'd0);
        check("rrst_dout", 32'(dout), 32'd0);
        check("rrst_err", 32'(err), 32'd0);
        check("rrst_bus", 32'({wb_rw_o, wb_adr_o, wb_dat_o}), 32'd0);
        rst = 1'b1;
        wb_ack_i = 3'b001;
        wb_dat_i = 24'hFFFFFF;
        repeat (4) @(negedge clk);
        check("late_ack_idle", 32'(wb_stb_o), 32'd0);
        check("late_ack_sb", sb.size(), 32'd0);
        wb_ack_i = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
